// File: rtl/bus_responder.sv
// Multiplexed-bus target: decodes an ALE-latched address window and turns each bus byte into one local access.
// Build option WAIT_STATE_EN: stretch accesses with ready until local_ack arrives, with a TIMEOUT fallback.
module bus_responder #(
  parameter logic [19:0] BASE     = 20'h00000,
  parameter logic [19:0] MASK     = 20'hF0000,
  parameter bit          IO_SPACE = 1'b0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] a,
  inout  wire  [7:0]  ad,
  input  logic        ale,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        iom,
  input  logic        den_n,
  input  logic        dtr,
  output logic        ready,
  output logic        local_req,
  output logic        local_we,
  output logic [19:0] local_addr,
  output logic [7:0]  local_wdata,
  input  logic [7:0]  local_rdata,
  input  logic        local_ack,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    END  = 3'd4
`ifdef WAIT_STATE_EN
    , WAIT = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic        iom_q, iom_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        wr_seen_q, wr_seen_d;
  logic        err_q, err_d;
  logic        req_c, we_c;
  logic        hit_c;
  logic        drive_c;

`ifdef WAIT_STATE_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             acc_we_q, acc_we_d;
`endif

  assign hit_c = ((a & MASK) == (BASE & MASK)) && (iom == IO_SPACE);

  // Next-state and request decode; ALE overrides whatever access is in flight.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iom_d     = iom_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_seen_d = wr_seen_q;
    err_d     = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
`ifdef WAIT_STATE_EN
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    acc_we_d  = acc_we_q;
`endif
    if (ale) begin
      addr_d    = a;
      iom_d     = iom;
      wr_seen_d = 1'b0;
      state_d   = hit_c ? SEL : IDLE;
`ifdef WAIT_STATE_EN
      ready_d   = 1'b1;
      cnt_d     = '0;
`endif
    end else begin
      case (state_q)
        SEL: begin
          if (!rd_n && !wr_n) begin
            err_d = 1'b1;
          end else if (!wr_n) begin
            wdata_d   = ad;
            wr_seen_d = 1'b1;
          end else if (wr_seen_q || !rd_n) begin
            // Write fires on the strobe's trailing edge, read on its first low cycle.
            req_c     = 1'b1;
            we_c      = wr_seen_q;
            wr_seen_d = 1'b0;
            state_d   = wr_seen_q ? WR : RD;
`ifdef WAIT_STATE_EN
            acc_we_d  = wr_seen_q;
            cnt_d     = '0;
            if (local_ack) begin
              if (!wr_seen_q) rdata_d = local_rdata;
            end else begin
              ready_d = 1'b0;
            end
`else
            if (!wr_seen_q) rdata_d = local_rdata;
`endif
          end
        end
`ifdef WAIT_STATE_EN
        RD, WR, WAIT: begin
          if (ready_q) begin
            state_d = END;
          end else if (local_ack) begin
            if (!acc_we_q) rdata_d = local_rdata;
            ready_d = 1'b1;
            state_d = END;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            if (!acc_we_q) rdata_d = 8'hFF;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = END;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = WAIT;
          end
        end
`else
        RD, WR: state_d = END;
`endif
        END: begin
          if (rd_n && wr_n) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      iom_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_seen_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef WAIT_STATE_EN
      ready_q   <= 1'b1;
      cnt_q     <= '0;
      acc_we_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iom_q     <= iom_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_seen_q <= wr_seen_d;
      err_q     <= err_d;
`ifdef WAIT_STATE_EN
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      acc_we_q  <= acc_we_d;
`endif
    end
  end

  // Read data goes onto the bus only while the initiator is actively sampling it.
  assign drive_c = ((state_q == RD) || (state_q == END)) && !rd_n && !den_n && !dtr;
  assign ad      = drive_c ? rdata_q : 8'hzz;

  assign local_req   = req_c;
  assign local_we    = we_c;
  assign local_addr  = addr_q;
  assign local_wdata = wdata_q;
  assign err         = err_q;

`ifdef WAIT_STATE_EN
  assign ready = ready_q;
  logic unused_sig;
  assign unused_sig = &{1'b0, iom_q};
`else
  assign ready = 1'b1;
  logic unused_sig;
  assign unused_sig = &{1'b0, iom_q, local_ack, TIMEOUT[0]};
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a scoreboard queue holds expected local requests, popped as the DUT issues them.
// The WAIT_STATE_EN sections run only when the design is built with that macro.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] a;
  wire  [7:0]  ad;
  logic        ale, rd_n, wr_n, iom, den_n, dtr;
  logic        ready, local_req, local_we, err;
  logic [19:0] local_addr;
  logic [7:0]  local_wdata, local_rdata;
  logic        local_ack;

  logic [7:0]  ad_drv;
  logic        ad_oe;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Released bus reads as 8'h00 through the pulldowns.
  assign ad = ad_oe ? ad_drv : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pd
    pulldown (ad[gi]);
  end

  bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .ad         (ad),
    .ale        (ale),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .iom        (iom),
    .den_n      (den_n),
    .dtr        (dtr),
    .ready      (ready),
    .local_req  (local_req),
    .local_we   (local_we),
    .local_addr (local_addr),
    .local_wdata(local_wdata),
    .local_rdata(local_rdata),
    .local_ack  (local_ack),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [19:0] addr, input logic [7:0] wdata);
    req_t e;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    sb_q.push_back(e);
  endtask

  task automatic addr_phase(input logic [19:0] addr, input logic io);
    a   = addr;
    iom = io;
    ale = 1'b1;
    cyc();
    ale = 1'b0;
  endtask

  task automatic idle_bus();
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    den_n     = 1'b1;
    dtr       = 1'b1;
    ad_oe     = 1'b0;
    local_ack = 1'b0;
  endtask

  // Every local_req must match the oldest expected access.
  req_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1 && local_req === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("no_unexpected_req", 32'(local_req), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("req_we", 32'(local_we), 32'(mon_e.we));
        check("req_addr", 32'(local_addr), 32'(mon_e.addr));
        if (mon_e.we) check("req_wdata", 32'(local_wdata), 32'(mon_e.wdata));
      end
    end
  end

  initial begin
    int low_cnt;
    int err_cnt;
    rst = 1'b0; ale = 1'b0; a = '0; iom = 1'b0;
    local_rdata = '0; ad_drv = '0;
    idle_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_req", 32'(local_req), 32'd0);
    check("rst_we", 32'(local_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(local_addr), 32'd0);
    check("rst_wdata", 32'(local_wdata), 32'd0);
    check("rst_ad", 32'(ad), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // Memory read, ack in the request cycle.
    addr_phase(20'h00123, 1'b0);
    push_exp(1'b0, 20'h00123, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'h5A; local_ack = 1'b1;
    @(negedge clk);
    check("rd_c1_ad_released", 32'(ad), 32'd0);
    cyc();
    local_rdata = 8'h00; local_ack = 1'b0;
    @(negedge clk);
    check("rd_c2_ad", 32'(ad), 32'h5A);
    check("rd_c2_single_req", 32'(local_req), 32'd0);
    check("rd_c2_ready", 32'(ready), 32'd1);
    cyc();
    @(negedge clk);
    check("rd_c3_ad", 32'(ad), 32'h5A);
    cyc();
    idle_bus();
    @(negedge clk);
    check("rd_end_ad_released", 32'(ad), 32'd0);
    cyc();

    // Memory write.
    addr_phase(20'h00200, 1'b0);
    wr_n = 1'b0; ad_oe = 1'b1; ad_drv = 8'hC3;
    @(negedge clk);
    check("wr_low_no_req", 32'(local_req), 32'd0);
    cyc();
    push_exp(1'b1, 20'h00200, 8'hC3);
    wr_n = 1'b1; ad_oe = 1'b0; ad_drv = 8'h00; local_ack = 1'b1;
    @(negedge clk);
    check("wr_req", 32'(local_req), 32'd1);
    check("wr_wdata", 32'(local_wdata), 32'hC3);
    cyc();
    local_ack = 1'b0;
    @(negedge clk);
    check("wr_single_req", 32'(local_req), 32'd0);
    cyc();
    cyc();

    // Out-of-window memory read, then an I/O cycle to a memory target.
    addr_phase(20'h10000, 1'b0);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'hE7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("oow_ad", 32'(ad), 32'd0);
      check("oow_req", 32'(local_req), 32'd0);
      cyc();
    end
    idle_bus();
    cyc();
    addr_phase(20'h00123, 1'b1);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("io_ad", 32'(ad), 32'd0);
      check("io_req", 32'(local_req), 32'd0);
      cyc();
    end
    idle_bus();
    iom = 1'b0;
    cyc();

    // Both strobes low: error pulse, no request, FSM stays selected.
    addr_phase(20'h00300, 1'b0);
    rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("both_low_no_req", 32'(local_req), 32'd0);
    cyc();
    rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    check("both_low_err", 32'(err), 32'd1);
    cyc();
    @(negedge clk);
    check("err_one_cycle", 32'(err), 32'd0);
    push_exp(1'b0, 20'h00300, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'hA5; local_ack = 1'b1;
    cyc();
    local_ack = 1'b0;
    @(negedge clk);
    check("sel_kept_ad", 32'(ad), 32'hA5);
    cyc();
    idle_bus();
    cyc();

    // New ALE (missing) in the middle of a read aborts it.
    addr_phase(20'h00400, 1'b0);
    push_exp(1'b0, 20'h00400, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'h11; local_ack = 1'b1;
    cyc();
    local_ack = 1'b0;
    addr_phase(20'h20000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("ale_abort_ad", 32'(ad), 32'd0);
      check("ale_abort_req", 32'(local_req), 32'd0);
      cyc();
    end
    idle_bus();
    addr_phase(20'h00500, 1'b0);
    push_exp(1'b0, 20'h00500, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'h3C; local_ack = 1'b1;
    cyc();
    local_ack = 1'b0;
    @(negedge clk);
    check("ale_restart_ad", 32'(ad), 32'h3C);
    cyc();
    idle_bus();
    cyc();

    // Reset in the middle of a write data phase.
    addr_phase(20'h00600, 1'b0);
    wr_n = 1'b0; ad_oe = 1'b1; ad_drv = 8'h77;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_wdata", 32'(local_wdata), 32'd0);
    check("rst_mid_addr", 32'(local_addr), 32'd0);
    check("rst_mid_req", 32'(local_req), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    wr_n = 1'b1; ad_oe = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_no_req", 32'(local_req), 32'd0);
    cyc();

`ifdef WAIT_STATE_EN
    // Ack delayed five cycles after the request.
    addr_phase(20'h00700, 1'b0);
    push_exp(1'b0, 20'h00700, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'h00; local_ack = 1'b0;
    @(negedge clk);
    check("w5_ready_req_cycle", 32'(ready), 32'd1);
    low_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      local_ack   = (k == 5);
      local_rdata = (k == 5) ? 8'h66 : 8'h00;
      @(negedge clk);
      if (ready === 1'b0) low_cnt++;
    end
    check("w5_ready_low_cycles", 32'(low_cnt), 32'd5);
    check("w5_ad", 32'(ad), 32'h66);
    cyc();
    idle_bus();
    cyc();

    // No ack: timeout.
    addr_phase(20'h00800, 1'b0);
    push_exp(1'b0, 20'h00800, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_rdata = 8'h12; local_ack = 1'b0;
    @(negedge clk);
    low_cnt = 0;
    err_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      @(negedge clk);
      if (ready === 1'b0) low_cnt++;
      if (err === 1'b1) err_cnt++;
    end
    check("to_ready_low_cycles", 32'(low_cnt), 32'd15);
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_ad", 32'(ad), 32'hFF);
    cyc();
    idle_bus();
    cyc();

    // Reset while waiting for ack.
    addr_phase(20'h00900, 1'b0);
    push_exp(1'b0, 20'h00900, 8'h00);
    rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0; local_ack = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_ready", 32'(ready), 32'd1);
    check("rst_wait_err", 32'(err), 32'd0);
    check("rst_wait_addr", 32'(local_addr), 32'd0);
    check("rst_wait_ad", 32'(ad), 32'd0);
    idle_bus();
    cyc();
    rst = 1'b1;
    cyc();
`endif

    cyc();
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameters SHALL be:
- BASE, 20'h00000: decode base address.
- MASK, 20'hF0000: decode compare mask.
- IO_SPACE, 0: 0 = respond to memory cycles (iom=0); 1 = respond to I/O cycles (iom=1).
- TIMEOUT, 15: maximum wait cycles for local_ack.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- a  in  20  bus address.
- ad  inout  8  multiplexed address/data bus.
- ale  in  1  address latch enable.
- rd_n  in  1  read strobe, active-low.
- wr_n  in  1  write strobe, active-low.
- iom  in  1  1 = I/O cycle, 0 = memory cycle.
- den_n  in  1  data enable, active-low.
- dtr  in  1  data direction; 0 = toward initiator.
- ready  out  1  0 = insert wait state.
- local_req  out  1  one-cycle local access request.
- local_we  out  1  local access is a write.
- local_addr  out  20  latched bus address.
- local_wdata  out  8  captured write byte.
- local_rdata  in  8  local read data.
- local_ack  in  1  local access complete.
- err  out  1  one-cycle protocol-error pulse.

Function
REQ-003 The FSM SHALL have states IDLE, SEL, RD, WR, WAIT and END.
REQ-004 In any state, ale=1 SHALL latch a into local_addr and iom into an internal flag; hit = ((a & MASK) == (BASE & MASK)) and (iom == IO_SPACE).
- hit SHALL move the FSM to SEL.
- no hit SHALL move it to IDLE, aborting any access in progress without issuing local_req.
REQ-005 In SEL, rd_n=0 with wr_n=1 SHALL assert local_req=1, local_we=0 combinationally that cycle and move to RD.
REQ-006 In SEL, any cycle with wr_n=0 SHALL capture ad into local_wdata; the first cycle with wr_n=1 after wr_n was low SHALL assert local_req=1, local_we=1 and move to WR.
REQ-007 rd_n=0 and wr_n=0 together in SEL SHALL pulse err for one cycle, issue no request and leave the FSM in SEL.
REQ-008 The cycle-1 read data SHALL be held in a read register, which drives ad from the next cycle, in time for the initiator's latch on the second rd_n-low cycle.
REQ-009 ad SHALL be driven only when state is RD or END, rd_n=0, den_n=0 and dtr=0; otherwise ad SHALL be high-impedance.
REQ-010 From RD or WR, the access completes as defined under Configuration; the FSM then moves to END.
REQ-011 In END, the FSM SHALL move to IDLE in the first cycle with rd_n=1 and wr_n=1.
REQ-012 local_req SHALL never be high for more than one cycle per bus cycle; each ALE-delimited byte is a separate access.

Reset
REQ-013 rst=0 SHALL asynchronously force state=IDLE, ready=1, local_req=0, local_we=0, err=0, local_addr=0, local_wdata=0, read register=0, wait counter=0, and ad released.
REQ-014 Reset asserted mid-access SHALL abort the access with no further local_req.

Configuration
REQ-015 With WAIT_STATE_EN defined:
- ready SHALL go 0 the cycle after local_req and return to 1 the cycle after local_ack.
- the read register SHALL load local_rdata on the local_ack cycle.
- if no local_ack arrives within TIMEOUT cycles, the read register SHALL load 8'hFF, err SHALL pulse, and ready SHALL return to 1.
REQ-016 Without WAIT_STATE_EN:
- ready SHALL be constant 1 and the WAIT state and timeout counter SHALL be absent.
- local_ack SHALL be ignored.
- the read register SHALL load local_rdata on the local_req cycle.

Verification
REQ-017 Memory read at a=20'h0_0123, BASE=0, local_rdata=8'h5A, ack same cycle -> one local_req with we=0; ad=8'h5A on the second rd_n-low cycle; ad=Z after rd_n rises.
REQ-018 Write at a=20'h0_0200 with ad=8'hC3 during wr_n low -> one local_req with we=1, local_addr=20'h00200, local_wdata=8'hC3 on the cycle after wr_n rises.
REQ-019 Out-of-window read at a=20'h1_0000, plus I/O cycle with IO_SPACE=0 -> no local_req; ad stays Z throughout.
REQ-020 WAIT_STATE_EN, local_ack delayed 5 cycles -> ready=0 for exactly 5 cycles; then ad=local_rdata. With no ack at all -> ready=0 for 15 cycles, err pulse, ad=8'hFF.
REQ-021 rd_n and wr_n low together -> err pulse and no local_req. A new ale mid-read restarts decode with no stray request. rst low mid-WAIT -> all outputs at reset values next cycle.
